// File: rtl/hc148_irq_controller.sv
// Eight-input interrupt controller with 74HC148 priority/cascade semantics,
// registered request capture, masking and an ack/timeout service handshake.
module hc148_irq_controller #(
    parameter bit          EDGE_MODE = 1'b1,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] ReqIn_n,
    input  logic [7:0] MaskIn,
    input  logic       MaskWe,
    input  logic       EI,
    input  logic       Ack,
    output logic       Irq,
    output logic [2:0] Vector,
    output logic       GS,
    output logic       EO,
    output logic       Busy,
    output logic       Timeout
);

    localparam int unsigned N  = 8;
    localparam int unsigned VW = 3;
    localparam int unsigned CW = 8;
    localparam logic [CW:0] TO_LIM = 9'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_req_q;
    logic [N-1:0]    r_req_qq;
    logic [N-1:0]    r_pending;
    logic [N-1:0]    r_mask;
    logic            r_irq;
    logic [VW-1:0]   r_vector;
    logic [CW-1:0]   r_cnt;
    logic            r_timeout;

    state_t          w_state_nxt;
    logic [N-1:0]    w_set;
    logic [N-1:0]    w_clr;
    logic [N-1:0]    w_eff;
    logic            w_any;
    logic [VW-1:0]   w_enc;
    logic            w_irq_nxt;
    logic [VW-1:0]   w_vector_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_timeout_nxt;
    logic [CW:0]     w_cnt_inc;
    logic            w_expired;

    assign w_set     = EDGE_MODE ? (~r_req_q & r_req_qq) : ~r_req_q;
    assign w_eff     = r_pending & ~r_mask;
    assign w_any     = |w_eff;
    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
    assign w_expired = (w_cnt_inc >= TO_LIM);

    // Highest set index wins; the loop runs upward so later hits override.
    always_comb begin
        w_enc = '0;
        for (int i = 0; i < N; i++) begin
            if (w_eff[i]) w_enc = 3'(i);
        end
    end

    // Only an acknowledged service clears its pending bit.
    always_comb begin
        w_clr = '0;
        if (r_state == S_SERVE && Ack) w_clr[r_vector] = 1'b1;
    end

    // Capture pipeline, pending and mask registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_req_q   <= 8'hFF;
            r_req_qq  <= 8'hFF;
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_req_q   <= ReqIn_n;
            r_req_qq  <= r_req_q;
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (MaskWe) r_mask <= MaskIn;
        end
    end

    // Service FSM state and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_irq     <= 1'b0;
            r_vector  <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_irq     <= w_irq_nxt;
            r_vector  <= w_vector_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_irq_nxt     = r_irq;
        w_vector_nxt  = r_vector;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!EI && w_any) begin
                    w_vector_nxt = w_enc;
                    w_irq_nxt    = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_SERVE;
                end
            end
            S_SERVE: begin
                w_cnt_nxt = w_expired ? TO_LIM[CW-1:0] : w_cnt_inc[CW-1:0];
                // Ack takes precedence over a simultaneous expiry.
                if (Ack) begin
                    w_irq_nxt   = 1'b0;
                    w_state_nxt = S_GAP;
                end else if (w_expired) begin
                    w_irq_nxt     = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_GAP;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_irq_nxt   = 1'b0;
            end
        endcase
    end

    assign Irq     = r_irq;
    assign Vector  = r_vector;
    assign Timeout = r_timeout;
    assign Busy    = (r_state != S_IDLE);
    assign GS      = EI | ~w_any;
    assign EO      = EI | w_any;

endmodule

// File: doc/hc148_irq_controller.md
# hc148_irq_controller

Eight-input interrupt controller that puts registered request capture, masking and an acknowledge handshake around 74HC148 priority semantics. Request inputs and the EI/EO/GS cascade pins keep the 74HC148's active-low conventions, so controllers chain like HC148 devices. The block sits between the raw active-low request lines and a single-interrupt consumer. It presents one vector at a time and holds it until the consumer acknowledges it or a timeout expires.

## Interface

Parameters:
- EDGE_MODE, 1, 1 = a pending bit is set on a high→low transition of the request; 0 = set while the request is low (level mode)
- TIMEOUT, 15, number of SERVE cycles without Ack before the service is abandoned; legal range 1–255

Ports:
- Clk  in  1  single clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-high reset
- ReqIn_n  in  8  active-low requests; bit 7 has the highest priority, bit 0 the lowest
- MaskIn  in  8  new mask value; a 1 masks that request
- MaskWe  in  1  mask register loads MaskIn on the edge where MaskWe=1
- EI  in  1  active-low enable, used as the cascade input
- Ack  in  1  acknowledge from the consumer; sampled only in SERVE
- Irq  out  1  active-high interrupt request
- Vector  out  3  true-binary index of the request being served; frozen while Irq=1
- GS  out  1  active-low; 0 when EI=0 and at least one unmasked pending bit exists
- EO  out  1  active-low; 0 when EI=0 and no unmasked pending bit exists (feeds EI of the next lower controller)
- Busy  out  1  1 in SERVE and GAP
- Timeout  out  1  one-cycle pulse when a service is abandoned

## Operation

- Capture
  - ReqIn_n is registered twice: req_q, then req_qq.
  - EDGE_MODE=1: pending[i] is set when req_q[i]=0 and req_qq[i]=1.
  - EDGE_MODE=0: pending[i] is set whenever req_q[i]=0.
- eff = pending & ~mask.
  - Priority encode of eff: the highest set index wins, with 74HC148 ordering.
  - GS and EO are combinational from EI and eff.
  - EI=1 forces GS=1 and EO=1.
- FSM states:
  - IDLE: if EI=0 and eff≠0, latch Vector = highest index of eff, set Irq=1, clear the counter, go to SERVE. Otherwise stay in IDLE.
  - SERVE: Vector is frozen and the counter increments each cycle.
    - Ack=1: clear pending[Vector], set Irq=0, go to GAP.
    - Otherwise, when the counter reaches TIMEOUT: set Irq=0, pulse Timeout, keep pending[Vector], go to GAP.
  - GAP: one cycle, then IDLE. Re-arbitration happens in IDLE.
- Boundary rules:
  - Ack and timeout expiry on the same edge: Ack wins and Timeout stays 0.
  - A set condition and an Ack clear on the same bit in the same cycle: set wins, so the bit stays pending.
  - Ack outside SERVE is ignored.
  - A mask write or EI→1 during SERVE does not end the current service. Masking only affects the next arbitration.
  - A higher-priority request arriving during SERVE does not preempt; it is served after GAP.
  - Level mode: the acked bit re-pends on the next edge if its request is still low.
  - Pending bits continue to latch while EI=1 or while the controller is in SERVE.
- Counter width: 8 bits; it saturates at TIMEOUT.

## Timing

- Values after any edge with Reset=1:
  - pending, mask, req_q and req_qq (register values): pending=0, mask=8'h00, req_q=req_qq=8'hFF
  - outputs: Irq=0, Vector=0, Busy=0, Timeout=0, GS=1, EO=EI
  - FSM state: IDLE
- Reset asserted mid-service drops Irq on that edge and discards all pending bits.
- Latency: ReqIn_n[i] sampled low at edge t (high at t−1):
  - edge-mode pending set at t+1
  - Irq=1 at t+2, provided the controller is in IDLE, EI=0 and the bit is unmasked
- Ack sampled at edge e: Irq=0 and the pending clear both happen at e. The state is GAP during e→e+1. The next Irq can come at e+2 at the earliest.
- Irq first high at edge s with no Ack: Timeout=1 and Irq=0 at edge s+TIMEOUT; Timeout returns to 0 at s+TIMEOUT+1.
- GS and EO follow the pending and mask registers with no additional latency, and follow EI combinationally.

## Test plan

- Reset, then pulse ReqIn_n[5] low for 1 cycle (edge mode) → Irq=1, Vector=5, GS=0 exactly 2 edges after the sample; Ack → Irq=0, GS=1, EO=0.
- Bits 2 and 6 fall on the same edge → Vector=6 first; after Ack and the 2-cycle gap, Vector=2.
- Write MaskIn=8'h80 with MaskWe, then pulse bit 7 → no Irq, GS=1, EO=0. Then write MaskIn=8'h00 → Irq=1, Vector=7.
- TIMEOUT=15, no Ack → Timeout pulses at edge s+15 and Irq drops. Irq returns at s+17 with the same Vector.
- EI=1 while bit 3 pends → Irq=0, GS=1, EO=1. Drive EI=0 → Irq=1, Vector=3 on the next edge.
- Level mode, hold bit 4 low and Ack → Irq re-asserts with Vector=4 at e+2. Assert Reset during SERVE → Irq=0 on that edge and pending=0.
